if_prefetch_queue: RTL and testbench
====================================

# if_prefetch_queue

Instruction-fetch front end of the 5-stage RISC-V pipeline. It owns the fetch PC and issues single-outstanding requests to instruction memory over a req/ack handshake, which tolerates variable latency. Returned words go into a small FIFO that feeds the IF_ID pipeline register as a valid/stall stream. Branch and jump redirects from the MEM stage flush the queue and drop any in-flight response.

## Interface
- DEPTH, 4, queue entries; a power of two and at least 2.
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- CLK  in  1  rising-edge clock.
- Resetn  in  1  asynchronous, active-low reset.
- imem_req  out  1  request valid; held high until imem_ack.
- imem_addr  out  32  word address of the request; stable while imem_req is high.
- imem_ack  in  1  response strobe; sampled at the edge; allowed in the first cycle of imem_req.
- imem_rdata  in  32  instruction word; valid when imem_ack is high.
- redirect  in  1  taken branch or jump from MEM ((Branch_M & Zero_M) | Jump_M).
- redirect_pc  in  32  new fetch target (Target_M).
- stall  in  1  hazard hold; the IF_ID consumer does not accept the current entry.
- if_valid  out  1  head entry present (count != 0).
- if_pc  out  32  PC of the head entry.
- if_instr  out  32  instruction of the head entry.
- q_count  out  $clog2(DEPTH)+1  occupancy, for debug and observation.

## Operation
- State: fetch_pc, FIFO (rd_ptr, wr_ptr, count), and an FSM with states IDLE, WAIT and DROP.
- imem_req = (state==WAIT) | (state==DROP). imem_addr is a register and changes only at edges.
- pop = if_valid & ~stall & ~redirect. The head advances at the edge.
- IDLE:
  - If redirect: fetch_pc <= redirect_pc, flush, stay IDLE.
  - Else if count < DEPTH: imem_addr <= fetch_pc, go to WAIT.
- WAIT:
  - If redirect & ack: discard rdata, flush, fetch_pc <= redirect_pc, go to IDLE.
  - If redirect & ~ack: flush, fetch_pc <= redirect_pc, go to DROP.
  - If ack: push {imem_addr, imem_rdata} and set fetch_pc <= imem_addr+4.
    - Back-to-back: if (count + 1 - pop) < DEPTH, stay in WAIT with imem_addr <= imem_addr+4.
    - Otherwise go to IDLE.
  - If ~ack: hold.
- DROP: hold the old imem_addr until ack, then discard and go to IDLE.
  - A further redirect while in DROP updates fetch_pc and re-flushes, staying in DROP.
- Flush: count=0, rd_ptr=wr_ptr=0.
- Priority: redirect > push/pop. In a redirect cycle nothing is pushed and nothing is popped.
- Push and pop in the same cycle leave count unchanged.
- Overflow is impossible by construction: a request is issued only with a free slot, and there is one outstanding request at most.
- Pop on empty is ignored.
- PC arithmetic is 32-bit modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0.
- Pointers wrap modulo DEPTH.
- if_pc/if_instr are driven from the storage at rd_ptr. Their values are don't-care when if_valid=0, except after reset.

## Timing
- Reset (asynchronous, any state, including a pending handshake):
  - State=IDLE, fetch_pc=RESET_PC, count=0, pointers=0.
  - imem_req=0, imem_addr=0.
  - Storage is cleared, so if_valid=0, if_pc=0, if_instr=0, q_count=0.
- Any pending memory response is abandoned on reset. The memory must not ack with imem_req low.
- No bypass: a word acked at edge N appears on if_valid/if_instr in cycle N+1.
- First fetch: the first request is high 1 cycle after reset deassert. With a zero-wait ack, if_valid=1 two cycles after reset deassert.
- Throughput with zero-wait memory and no stall is one instruction per cycle in steady state.
- Redirect at edge N:
  - if_valid=0 from cycle N+1.
  - From IDLE, or WAIT with ack, the request for redirect_pc is issued in cycle N+1.
  - From DROP, it is issued in the cycle after the dropped ack.
- Outputs in the redirect cycle still show the old head. The top flushes IF_ID on the same signal.

## Test plan
- Reset, then zero-wait memory returning the word addr^32'hA5A5_0000 with stall=0 → if_pc sequence 0,4,8,… on consecutive cycles; if_instr matches; q_count ≤1.
- stall=1 held for 10 cycles, zero-wait memory → queue fills: q_count=4, imem_req=0, if_pc=0 held. Release stall → pops 0,4,8,12,16 in order with no gap or duplicate.
- 3-cycle ack latency and redirect with redirect_pc=32'h100 in the 2nd wait cycle → old ack discarded; next request addr=32'h100; first valid if_pc=32'h100; no stale entry is delivered.
- Redirect asserted in the same cycle as ack and a pop, with q_count=2 → q_count=0 next cycle; no push; fetch_pc=redirect_pc.
- RESET_PC=32'hFFFF_FFF8, free-running fetch → if_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Resetn pulled low mid-WAIT with q_count=3 → immediately imem_req=0, if_valid=0, q_count=0. After release, fetching restarts at RESET_PC.

Source files
------------

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues one outstanding
// imem request at a time and buffers returned words in a small FIFO.
module if_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     CLK,
    input  logic                     Resetn,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_ack,
    input  logic [31:0]              imem_rdata,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    input  logic                     stall,
    output logic                     if_valid,
    output logic [31:0]              if_pc,
    output logic [31:0]              if_instr,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [31:0]     fetch_pc_q;
    logic [31:0]     fetch_pc_d;
    logic [31:0]     addr_q;
    logic [31:0]     addr_d;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_after_push;
    logic [31:0]     pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];
    logic            push;
    logic            pop;
    logic            flush;

    assign if_valid  = (count_q != '0);
    assign pop       = if_valid & ~stall & ~redirect;
    assign flush     = redirect;
    assign imem_req  = (state_q == WAIT) | (state_q == DROP);
    assign imem_addr = addr_q;
    assign if_pc     = pc_mem[rd_ptr_q];
    assign if_instr  = instr_mem[rd_ptr_q];
    assign q_count   = count_q;

    // Occupancy after this cycle's push, used to decide back-to-back issue.
    assign count_after_push = count_q + CW'(1) - {{(CW-1){1'b0}}, pop};

    // FSM register, fetch PC and request address.
    always_ff @(posedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= 32'h0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    // Next-state: issue, back-to-back refetch, and redirect handling.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        push       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end else if (count_q < FULL) begin
                    addr_d  = fetch_pc_q;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                    state_d    = imem_ack ? IDLE : DROP;
                end else if (imem_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = addr_q + 32'd4;
                    if (count_after_push < FULL) begin
                        addr_d = addr_q + 32'd4;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                // The stale response still has to be absorbed; a new
                // redirect only retargets where fetch resumes.
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end
                if (imem_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO pointers and occupancy; a redirect flushes everything.
    always_ff @(posedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q
                     + {{(CW-1){1'b0}}, push}
                     - {{(CW-1){1'b0}}, pop};
        end
    end

    // Entry storage; cleared on reset so the head reads as zero.
    always_ff @(posedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= 32'h0;
                instr_mem[i] <= 32'h0;
            end
        end else if (push) begin
            pc_mem[wr_ptr_q]    <= addr_q;
            instr_mem[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: queue-based reference model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_if_prefetch_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          CLK = 1'b0;
    logic          Resetn = 1'b0;
    logic          imem_req;
    logic [31:0]   imem_addr;
    logic          imem_ack = 1'b0;
    logic [31:0]   imem_rdata = 32'h0;
    logic          redirect = 1'b0;
    logic [31:0]   redirect_pc = 32'h0;
    logic          stall = 1'b0;
    logic          if_valid;
    logic [31:0]   if_pc;
    logic [31:0]   if_instr;
    logic [CW-1:0] q_count;

    logic          req2;
    logic [31:0]   addr2;
    logic          valid2;
    logic [31:0]   pc2;
    logic [31:0]   instr2;
    logic [CW-1:0] qc2;
    logic          ack2;
    logic [31:0]   rdata2;

    always #5 CLK = ~CLK;

    if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .CLK(CLK), .Resetn(Resetn),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .stall(stall),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .q_count(q_count)
    );

    // Second instance: free-running, zero-wait memory, wrapping PC.
    assign ack2   = req2;
    assign rdata2 = addr2 ^ 32'hA5A5_0000;

    if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut2 (
        .CLK(CLK), .Resetn(Resetn),
        .imem_req(req2), .imem_addr(addr2),
        .imem_ack(ack2), .imem_rdata(rdata2),
        .redirect(1'b0), .redirect_pc(32'h0),
        .stall(1'b0),
        .if_valid(valid2), .if_pc(pc2), .if_instr(instr2),
        .q_count(qc2)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    bit          m_busy;
    bit          m_drop;
    logic [31:0] m_fpc;
    logic [31:0] m_addr;
    int          lat_left;
    int          lat_min;
    int          lat_max;
    logic [31:0] pops[$];
    int          n_tot = 0;
    int          n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic m_reset();
        mq.delete();
        m_busy   = 1'b0;
        m_drop   = 1'b0;
        m_fpc    = 32'h0;
        m_addr   = 32'h0;
        lat_left = -1;
    endtask

    task automatic compare();
        chk("imem_req", imem_req, 32'(m_busy));
        chk("imem_addr", imem_addr, m_addr);
        chk("if_valid", if_valid, 32'(mq.size() != 0));
        chk("q_count", 32'(q_count), mq.size());
        if (mq.size() != 0) begin
            chk("if_pc", if_pc, mq[0].pc);
            chk("if_instr", if_instr, mq[0].instr);
        end
    endtask

    // Reference: one request in flight, queue of fetched words.
    task automatic model_update(input logic st, input logic rd,
                                input logic [31:0] rpc, input logic ack,
                                input logic [31:0] rdat);
        bit pop;
        int after;
        pop = (mq.size() != 0) && !st && !rd;
        if (rd) begin
            mq.delete();
            m_fpc = rpc;
            if (m_busy && !m_drop) begin
                if (ack) m_busy = 1'b0;
                else m_drop = 1'b1;
            end else if (m_drop && ack) begin
                m_busy = 1'b0;
                m_drop = 1'b0;
            end
        end else begin
            if (!m_busy) begin
                if (mq.size() < DEPTH) begin
                    m_addr = m_fpc;
                    m_busy = 1'b1;
                end
            end else if (m_drop) begin
                if (ack) begin
                    m_busy = 1'b0;
                    m_drop = 1'b0;
                end
            end else if (ack) begin
                after = mq.size() + 1 - (pop ? 1 : 0);
                mq.push_back('{m_addr, rdat});
                m_fpc = m_addr + 32'd4;
                if (after < DEPTH) m_addr = m_addr + 32'd4;
                else m_busy = 1'b0;
            end
            if (pop) void'(mq.pop_front());
        end
    endtask

    // One cycle, entered and left at a falling edge.
    task automatic step(input logic st, input logic rd,
                        input logic [31:0] rpc);
        logic ack;
        compare();
        if (m_busy && lat_left < 0) lat_left = $urandom_range(lat_max, lat_min);
        ack = m_busy && (lat_left == 0);
        if (m_busy && lat_left > 0) lat_left--;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        imem_ack    = ack;
        imem_rdata  = ack ? (m_addr ^ 32'hA5A5_0000) : $urandom;
        if (mq.size() != 0 && !st && !rd) pops.push_back(mq[0].pc);
        @(posedge CLK);
        model_update(st, rd, rpc, ack, imem_rdata);
        if (ack) lat_left = -1;
        @(negedge CLK);
    endtask

    task automatic do_reset();
        Resetn      = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        m_reset();
        pops.delete();
        repeat (2) @(negedge CLK);
        chk("rst_req", imem_req, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", if_valid, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_qcount", 32'(q_count), 32'h0);
        Resetn = 1'b1;
    endtask

    initial begin
        lat_min = 0;
        lat_max = 0;
        m_reset();

        // Zero-wait streaming, plus the wrapping-PC instance.
        do_reset();
        for (int c = 0; c < 12; c++) begin
            if (c == 2) begin
                chk("first_valid", if_valid, 32'h1);
                chk("wrap_valid", valid2, 32'h1);
                chk("wrap_pc0", pc2, 32'hFFFF_FFF8);
                chk("wrap_instr0", instr2, 32'h5A5A_FFF8);
            end
            if (c == 3) chk("wrap_pc1", pc2, 32'hFFFF_FFFC);
            if (c == 4) chk("wrap_pc2", pc2, 32'h0000_0000);
            step(1'b0, 1'b0, 32'h0);
        end
        chk("stream_pops", 32'(pops.size() >= 5), 32'h1);
        for (int i = 0; i < 5 && i < pops.size(); i++)
            chk("stream_pc", pops[i], 32'(i * 4));

        // Stall fills the queue, then drains in order.
        do_reset();
        for (int c = 0; c < 10; c++) step(1'b1, 1'b0, 32'h0);
        chk("full_qcount", 32'(q_count), 32'd4);
        chk("full_req", imem_req, 32'h0);
        chk("full_pc", if_pc, 32'h0);
        for (int c = 0; c < 20; c++) step(1'b0, 1'b0, 32'h0);
        chk("drain_pops", 32'(pops.size() >= 5), 32'h1);
        for (int i = 0; i < 5 && i < pops.size(); i++)
            chk("drain_pc", pops[i], 32'(i * 4));

        // Redirect while a 3-cycle-latency request is outstanding.
        do_reset();
        lat_min = 3;
        lat_max = 3;
        for (int c = 0; c < 16; c++) begin
            if (c == 6) begin
                chk("drop_req", imem_req, 32'h1);
                chk("drop_newaddr", imem_addr, 32'h100);
            end
            step(1'b0, c == 2, 32'h100);
        end
        chk("drop_pops", 32'(pops.size() >= 1), 32'h1);
        if (pops.size() >= 1) chk("drop_first_pc", pops[0], 32'h100);

        // Redirect coinciding with ack and pop at q_count=2.
        do_reset();
        lat_min = 0;
        lat_max = 0;
        for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 32'h0);
        chk("rda_qcount", 32'(q_count), 32'd2);
        chk("rda_req", imem_req, 32'h1);
        step(1'b0, 1'b1, 32'h200);
        chk("rda_flush_q", 32'(q_count), 32'd0);
        chk("rda_flush_v", if_valid, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("rda_newaddr", imem_addr, 32'h200);
        for (int c = 0; c < 6; c++) step(1'b0, 1'b0, 32'h0);

        // Asynchronous reset with a request pending and q_count=3.
        do_reset();
        for (int c = 0; c < 4; c++) step(1'b1, 1'b0, 32'h0);
        lat_min = 6;
        lat_max = 6;
        step(1'b1, 1'b0, 32'h0);
        chk("arst_pre_q", 32'(q_count), 32'd3);
        chk("arst_pre_req", imem_req, 32'h1);
        #2 Resetn = 1'b0;
        #1;
        chk("arst_req", imem_req, 32'h0);
        chk("arst_valid", if_valid, 32'h0);
        chk("arst_qcount", 32'(q_count), 32'h0);
        do_reset();
        lat_min = 0;
        lat_max = 0;
        step(1'b0, 1'b0, 32'h0);
        chk("arst_restart_req", imem_req, 32'h1);
        chk("arst_restart_addr", imem_addr, 32'h0);
        for (int c = 0; c < 5; c++) step(1'b0, 1'b0, 32'h0);

        // Randomized traffic: latency, stalls and redirects.
        do_reset();
        lat_min = 0;
        lat_max = 3;
        for (int c = 0; c < 4000; c++) begin
            step($urandom_range(99) < 35, $urandom_range(99) < 7,
                 $urandom & 32'hFFFF_FFFC);
        end
        lat_max = 1;
        for (int c = 0; c < 2000; c++) begin
            step($urandom_range(99) < 60, $urandom_range(99) < 3,
                 $urandom & 32'hFFFF_FFFC);
        end
        compare();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
